// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Unsigned DIVIDEND_W / DIVISOR_W -> quotient, remainder, divide-by-zero flag.
module seq_divider #(
    parameter int unsigned DIVIDEND_W = 8,
    parameter int unsigned DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state, state_next;
    logic [DIVIDEND_W-1:0]   shreg, shreg_next;
    logic [DIVISOR_W-1:0]    dvsr, dvsr_next;
    logic [DIVISOR_W-1:0]    partial, partial_next;
    logic [CW-1:0]           count, count_next;
    logic [DIVIDEND_W-1:0]   quotient_next;
    logic [DIVISOR_W-1:0]    remainder_next;
    logic                    dz_next;
    logic                    done_next;

    logic [DIVISOR_W:0]      shifted;
    logic [DIVISOR_W-1:0]    diff_lo;
    logic                    q_bit;
    logic [DIVIDEND_W-1:0]   shreg_shifted;

    // The restored partial remainder is always below the divisor, so only the
    // shifted trial value needs the extra bit; the stored partial omits it.
    always_comb begin
        shifted       = {partial, shreg[DIVIDEND_W-1]};
        q_bit         = (shifted >= {1'b0, dvsr});
        diff_lo       = shifted[DIVISOR_W-1:0] - dvsr;
        shreg_shifted = {shreg[DIVIDEND_W-2:0], q_bit};
    end

    always_comb begin
        state_next     = state;
        shreg_next     = shreg;
        dvsr_next      = dvsr;
        partial_next   = partial;
        count_next     = count;
        quotient_next  = quotient;
        remainder_next = remainder;
        dz_next        = div_by_zero;
        done_next      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = RUN;
                    shreg_next   = dividend;
                    dvsr_next    = divisor;
                    partial_next = '0;
                    count_next   = CW'(DIVIDEND_W - 1);
                end
            end
            RUN: begin
                partial_next = q_bit ? diff_lo : shifted[DIVISOR_W-1:0];
                shreg_next   = shreg_shifted;
                count_next   = count - CW'(1);
                if (count == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                    if (dvsr == '0) begin
                        quotient_next  = '1;
                        remainder_next = '0;
                        dz_next        = 1'b1;
                    end else begin
                        quotient_next  = shreg_shifted;
                        remainder_next = partial_next;
                        dz_next        = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            dvsr        <= '0;
            partial     <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            dvsr        <= dvsr_next;
            partial     <= partial_next;
            count       <= count_next;
            quotient    <= quotient_next;
            remainder   <= remainder_next;
            div_by_zero <= dz_next;
            done        <= done_next;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model with per-cycle
// compare, directed boundary/handshake cases, and an exhaustive randomized sweep.
module tb_seq_divider;

    localparam int unsigned DW = 8;
    localparam int unsigned VW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy, done, div_by_zero;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request completes DW edges later with plain / and %.
    logic          m_busy = 1'b0;
    int            m_left = 0;
    int unsigned   m_a = 0, m_b = 0;
    logic          exp_done = 1'b0, exp_dz = 1'b0;
    logic [DW-1:0] exp_q = '0;
    logic [VW-1:0] exp_r = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_left <= 0; exp_done <= 1'b0;
            exp_q <= '0; exp_r <= '0; exp_dz <= 1'b0;
        end else begin
            exp_done <= 1'b0;
            if (m_busy) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy   <= 1'b0;
                    exp_done <= 1'b1;
                    if (m_b == 0) begin
                        exp_q <= '1; exp_r <= '0; exp_dz <= 1'b1;
                    end else begin
                        exp_q <= DW'(m_a / m_b); exp_r <= VW'(m_a % m_b); exp_dz <= 1'b0;
                    end
                end
            end else if (start) begin
                m_a <= dividend; m_b <= divisor; m_busy <= 1'b1; m_left <= DW;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, exp_done);
        chk("quotient", quotient, exp_q);
        chk("remainder", remainder, exp_r);
        chk("div_by_zero", div_by_zero, exp_dz);
    end

    // Issue one division starting now; waits (bounded) for done.
    task automatic run(input int unsigned a, input int unsigned b, input int unsigned eq,
                       input int unsigned er, input int unsigned edz, input bit lit,
                       input bit rnd, input int inj);
        int bc;
        bit seen;
        bc = 0;
        seen = 1'b0;
        start = 1'b1; dividend = DW'(a); divisor = VW'(b);
        @(posedge clk); #1;
        start = 1'b0; dividend = DW'($urandom); divisor = VW'($urandom);
        chk("busy_after_accept", busy, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                start = 1'b0;
                seen = 1'b1;
                break;
            end
            if (busy) bc++;
            if (bc == inj) begin
                start = 1'b1; dividend = 8'd50; divisor = 4'd5;
            end else if (rnd) begin
                start = ($urandom_range(0, 3) == 0);
                dividend = DW'($urandom); divisor = VW'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk("done_seen", seen, 1);
        chk("busy_cycles", bc, DW);
        if (lit) begin
            chk("lit_quotient", quotient, eq);
            chk("lit_remainder", remainder, er);
            chk("lit_div_by_zero", div_by_zero, edz);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_quotient", quotient, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;

        run(200, 7, 28, 4, 0, 1'b1, 1'b0, -1);
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        run(255, 1, 255, 0, 0, 1'b1, 1'b0, -1);
        run(255, 15, 17, 0, 0, 1'b1, 1'b0, -1);
        run(0, 9, 0, 0, 0, 1'b1, 1'b0, -1);
        run(14, 15, 0, 14, 0, 1'b1, 1'b0, -1);
        run(100, 0, 255, 0, 1, 1'b1, 1'b0, -1);
        run(9, 3, 3, 0, 0, 1'b1, 1'b0, -1);

        // Start pulse mid-operation must be ignored, then back-to-back on done.
        @(negedge clk);
        run(200, 7, 28, 4, 0, 1'b1, 1'b0, 3);
        run(50, 5, 10, 0, 0, 1'b1, 1'b0, -1);

        // Reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_by_zero", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
        end
        run(13, 4, 3, 1, 0, 1'b1, 1'b0, -1);

        // Exhaustive sweep with random gaps, ignored start pulses and operand noise.
        for (int unsigned a = 0; a < (1 << DW); a++) begin
            for (int unsigned b = 0; b < (1 << VW); b++) begin
                repeat ($urandom_range(0, 1)) @(negedge clk);
                run(a, b, 0, 0, 0, 1'b0, 1'b1, -1);
            end
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
